lc4_trace_recorder: RTL and testbench
=====================================

// Module: lc4_trace_recorder
// PURPOSE
// - Producer side of the LC4 retirement trace: snoops the processor's test_* commit stream and
//   emits one packed record per retired insn (test_stall==0) into a FIFO.
// - Records drain over a valid/ready port to a trace writer or host link.
// - Counts cycles by category (exec / cache / branch / load stall) for on-chip CPI reporting.
// - Sits beside lc4_processor in lc4_system, sampled on gwe like all architectural state.
// PARAMETERS
// - WORD_SIZE   64  width of regfile and dmem data fields
// - DEPTH_LOG2  4   FIFO depth = 2**DEPTH_LOG2 records
// - CNT_W       32  width of each statistics counter
// PORTS
// - clk               in   1      system clock
// - rst               in   1      synchronous, active-high reset
// - gwe               in   1      global write enable; sample inputs only when 1
// - i_enable          in   1      recording enable; 0 = ignore commit stream
// - test_stall        in   2      0 exec, 1 cache, 2 branch, 3 load stall
// - test_cur_pc       in   16     committed PC
// - test_cur_insn     in   16     committed insn bits
// - test_regfile_we   in   1      regfile write enable
// - test_regfile_wsel in   3      regfile dest
// - test_regfile_data in   WORD_SIZE  regfile write data
// - test_nzp_we       in   1      NZP write enable
// - test_nzp_new_bits in   3      NZP value
// - test_dmem_we      in   1      dmem write enable
// - test_dmem_addr    in   3      dmem address
// - test_dmem_data    in   WORD_SIZE  dmem data
// - o_rec             out  44+2*WORD_SIZE  {pc,insn,rf_we,wsel,rf_data,nzp_we,nzp,dm_we,dm_addr,dm_data}
// - o_rec_valid       out  1      o_rec holds head record
// - i_rec_ready       in   1      consumer accepts head this cycle when valid
// - o_overflow        out  1      sticky: a record was dropped
// - o_drop_cnt        out  CNT_W  dropped records, saturating
// - o_cnt_cycles/exec/cache/branch/load  out  CNT_W each  cycle statistics
// BEHAVIOUR
// - Reset: FIFO empty, o_rec_valid=0, o_rec=0, o_overflow=0, all counters 0. rst wins over all.
// - Sample event S = gwe & i_enable. Push P = S & (test_stall==0). Pop Q = o_rec_valid & i_rec_ready.
// - Push captures fields; record visible at o_rec one cycle after the sampling edge (FWFT head reg).
// - o_rec stable while o_rec_valid & !i_rec_ready; cannot change or deassert without pop.
// - Full & P & !Q: record dropped, o_overflow<=1, o_drop_cnt++. Full & P & Q: push accepted.
// - Empty & P & Q impossible (valid=0); no combinational bypass, min latency 1 cycle.
// - Pointers wrap modulo 2**DEPTH_LOG2; occupancy counter DEPTH_LOG2+1 bits, exact full/empty.
// - Fields with *_we=0 are recorded as sampled (no masking); consumer ignores them.
// - Stall codes X/Z: treated as no event; neither push nor counter increment.
// - i_enable deassert: in-flight FIFO contents still drain; no new pushes or counts.
// - Counters saturate at all-ones (no wrap). o_overflow clears only on rst.
// CONFIGURATION
// - TRACE_STATS_EN defined: o_cnt_* count on each S (cycles always, one category per stall code).
// - TRACE_STATS_EN undefined: counter logic removed, o_cnt_* tied 0; drop counter and FIFO unchanged.
// TESTING
// - Reset, then 3 commits pc=8200,8201,8202 with ready=1 -> 3 records in order, valid 1 cycle after each.
// - ready=0, 16 commits then 17th (DEPTH_LOG2=4) -> 16 held, o_overflow=1, o_drop_cnt=1, head pc unchanged.
// - FIFO full, commit with ready=1 same cycle -> push accepted, no drop, occupancy stays 16.
// - Stream stall codes 0,1,1,2,3,0 with gwe=1 -> cycles=6 exec=2 cache=2 branch=1 load=1 (STATS_EN).
// - gwe=0 or i_enable=0 with stall=0 -> no push, counters unchanged; rst mid-drain -> valid=0 next cycle.
// - Preload counter near max (force) and stall=0 -> saturates at 32'hFFFF_FFFF, no wrap.

Source files
------------

// File: rtl/lc4_trace_recorder.sv
// rtl/lc4_trace_recorder.sv - LC4 retirement trace recorder: commit-stream snooper, record FIFO, CPI counters
// Optional cycle statistics are built only when TRACE_STATS_EN is defined.
module lc4_trace_recorder #(
    parameter int WORD_SIZE  = 64,
    parameter int DEPTH_LOG2 = 4,
    parameter int CNT_W      = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        gwe,
    input  logic                        i_enable,
    input  logic [1:0]                  test_stall,
    input  logic [15:0]                 test_cur_pc,
    input  logic [15:0]                 test_cur_insn,
    input  logic                        test_regfile_we,
    input  logic [2:0]                  test_regfile_wsel,
    input  logic [WORD_SIZE-1:0]        test_regfile_data,
    input  logic                        test_nzp_we,
    input  logic [2:0]                  test_nzp_new_bits,
    input  logic                        test_dmem_we,
    input  logic [2:0]                  test_dmem_addr,
    input  logic [WORD_SIZE-1:0]        test_dmem_data,
    output logic [44+2*WORD_SIZE-1:0]   o_rec,
    output logic                        o_rec_valid,
    input  logic                        i_rec_ready,
    output logic                        o_overflow,
    output logic [CNT_W-1:0]            o_drop_cnt,
    output logic [CNT_W-1:0]            o_cnt_cycles,
    output logic [CNT_W-1:0]            o_cnt_exec,
    output logic [CNT_W-1:0]            o_cnt_cache,
    output logic [CNT_W-1:0]            o_cnt_branch,
    output logic [CNT_W-1:0]            o_cnt_load
);
    localparam int REC_W = 44 + 2*WORD_SIZE;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int OCC_W = DEPTH_LOG2 + 1;

    logic [REC_W-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      count_q, count_d;
    logic [REC_W-1:0]      rec_q, rec_d, new_rec;
    logic                  valid_q;
    logic                  overflow_q;
    logic [CNT_W-1:0]      drop_cnt_q;

    logic samp, known, st_exec, st_cache, st_branch, st_load;
    logic full, push_evt, push_ok, pop, drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != {CNT_W{1'b1}})) ? v + 1'b1 : v;
    endfunction

    // Unknown stall codes match no item, so they neither push nor count.
    always_comb begin
        known     = 1'b0;
        st_exec   = 1'b0;
        st_cache  = 1'b0;
        st_branch = 1'b0;
        st_load   = 1'b0;
        case (test_stall)
            2'd0: begin known = 1'b1; st_exec   = 1'b1; end
            2'd1: begin known = 1'b1; st_cache  = 1'b1; end
            2'd2: begin known = 1'b1; st_branch = 1'b1; end
            2'd3: begin known = 1'b1; st_load   = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        samp     = gwe & i_enable;
        push_evt = samp & st_exec;
        full     = (count_q == OCC_W'(DEPTH));
        pop      = valid_q & i_rec_ready;
        push_ok  = push_evt & (~full | pop);
        drop     = push_evt & full & ~pop;
        count_d  = count_q + OCC_W'(push_ok) - OCC_W'(pop);
        wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(push_ok);
        rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop);
        new_rec  = {test_cur_pc, test_cur_insn, test_regfile_we, test_regfile_wsel,
                    test_regfile_data, test_nzp_we, test_nzp_new_bits, test_dmem_we,
                    test_dmem_addr, test_dmem_data};
        // Head register: a push into an otherwise-empty FIFO bypasses the array read.
        if (count_d == '0)
            rec_d = '0;
        else if (push_ok && (count_q == OCC_W'(pop)))
            rec_d = new_rec;
        else
            rec_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= new_rec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rec_q      <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rec_q      <= rec_d;
            valid_q    <= (count_d != '0);
            overflow_q <= overflow_q | drop;
            drop_cnt_q <= sat_inc(drop_cnt_q, drop);
        end
    end

    assign o_rec       = rec_q;
    assign o_rec_valid = valid_q;
    assign o_overflow  = overflow_q;
    assign o_drop_cnt  = drop_cnt_q;

`ifdef TRACE_STATS_EN
    logic [CNT_W-1:0] cyc_q, exec_q, cache_q, branch_q, load_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q    <= '0;
            exec_q   <= '0;
            cache_q  <= '0;
            branch_q <= '0;
            load_q   <= '0;
        end else begin
            cyc_q    <= sat_inc(cyc_q,    samp & known);
            exec_q   <= sat_inc(exec_q,   samp & st_exec);
            cache_q  <= sat_inc(cache_q,  samp & st_cache);
            branch_q <= sat_inc(branch_q, samp & st_branch);
            load_q   <= sat_inc(load_q,   samp & st_load);
        end
    end

    assign o_cnt_cycles = cyc_q;
    assign o_cnt_exec   = exec_q;
    assign o_cnt_cache  = cache_q;
    assign o_cnt_branch = branch_q;
    assign o_cnt_load   = load_q;
`else
    assign o_cnt_cycles = '0;
    assign o_cnt_exec   = '0;
    assign o_cnt_cache  = '0;
    assign o_cnt_branch = '0;
    assign o_cnt_load   = '0;
`endif

endmodule

// File: tb/tb_lc4_trace_recorder.sv
// tb/tb_lc4_trace_recorder.sv - scoreboard bench for lc4_trace_recorder
module tb_lc4_trace_recorder;
    localparam int WS    = 64;
    localparam int REC_W = 44 + 2*WS;
    localparam int DEPTH = 16;
`ifdef TRACE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, rst_s, gwe, en, ready, ready_s;
    logic [1:0]       stall;
    logic [15:0]      pc, insn;
    logic             rf_we, nzp_we, dm_we;
    logic [2:0]       wsel, nzp, dm_addr;
    logic [WS-1:0]    rf_data, dm_data;
    logic [REC_W-1:0] rec, rec_s;
    logic             valid, valid_s, ovf, ovf_s;
    logic [31:0]      drop, cyc, c_exec, c_cache, c_branch, c_load;
    logic [3:0]       drop_s, cyc_s, exec_s, cache_s, branch_s, load_s;

    lc4_trace_recorder #(.WORD_SIZE(WS), .DEPTH_LOG2(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .gwe(gwe), .i_enable(en), .test_stall(stall),
        .test_cur_pc(pc), .test_cur_insn(insn), .test_regfile_we(rf_we),
        .test_regfile_wsel(wsel), .test_regfile_data(rf_data), .test_nzp_we(nzp_we),
        .test_nzp_new_bits(nzp), .test_dmem_we(dm_we), .test_dmem_addr(dm_addr),
        .test_dmem_data(dm_data), .o_rec(rec), .o_rec_valid(valid), .i_rec_ready(ready),
        .o_overflow(ovf), .o_drop_cnt(drop), .o_cnt_cycles(cyc), .o_cnt_exec(c_exec),
        .o_cnt_cache(c_cache), .o_cnt_branch(c_branch), .o_cnt_load(c_load));

    // Small instance used only to reach counter saturation in a few cycles.
    lc4_trace_recorder #(.WORD_SIZE(WS), .DEPTH_LOG2(1), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst_s), .gwe(gwe), .i_enable(en), .test_stall(stall),
        .test_cur_pc(pc), .test_cur_insn(insn), .test_regfile_we(rf_we),
        .test_regfile_wsel(wsel), .test_regfile_data(rf_data), .test_nzp_we(nzp_we),
        .test_nzp_new_bits(nzp), .test_dmem_we(dm_we), .test_dmem_addr(dm_addr),
        .test_dmem_data(dm_data), .o_rec(rec_s), .o_rec_valid(valid_s), .i_rec_ready(ready_s),
        .o_overflow(ovf_s), .o_drop_cnt(drop_s), .o_cnt_cycles(cyc_s), .o_cnt_exec(exec_s),
        .o_cnt_cache(cache_s), .o_cnt_branch(branch_s), .o_cnt_load(load_s));

    int total = 0;
    int bad   = 0;
    logic [REC_W-1:0] sb_q[$];
    int mcount = 0;
    int m_drop = 0, m_cyc = 0, m_exec = 0, m_cache = 0, m_branch = 0, m_load = 0;
    bit m_ovf = 1'b0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [REC_W-1:0] mkrec(input logic [15:0] p);
        logic [15:0] d;
        d = p ^ 16'h1234;
        return {p, p ^ 16'h5A5A, p[0], p[2:0], {p, ~p, p, p}, p[1], p[5:3], p[2], p[8:6], {4{d}}};
    endfunction

    task automatic drive(input logic [15:0] p, input logic [1:0] s, input logic g, input logic e);
        logic [15:0] d;
        d = p ^ 16'h1234;
        pc = p; insn = p ^ 16'h5A5A; rf_we = p[0]; wsel = p[2:0]; rf_data = {p, ~p, p, p};
        nzp_we = p[1]; nzp = p[5:3]; dm_we = p[2]; dm_addr = p[8:6]; dm_data = {4{d}};
        stall = s; gwe = g; en = e;
    endtask

    // One clock: check head against scoreboard at negedge, advance the model, step past posedge.
    task automatic tick();
        bit samp, push, pop;
        @(negedge clk);
        check("valid", 256'(valid), 256'(mcount > 0));
        pop = !rst && (mcount > 0) && ready;
        if (!rst && valid && ready) begin
            if (sb_q.size() == 0) check("sb_empty", 256'(1), 256'(0));
            else check("rec", 256'(rec), 256'(sb_q.pop_front()));
        end
        samp = gwe && en;
        push = samp && (stall == 2'd0);
        if (rst) begin
            mcount = 0; sb_q.delete(); m_ovf = 0; m_drop = 0;
            m_cyc = 0; m_exec = 0; m_cache = 0; m_branch = 0; m_load = 0;
        end else begin
            if (samp) begin
                m_cyc++;
                case (stall)
                    2'd0: m_exec++;
                    2'd1: m_cache++;
                    2'd2: m_branch++;
                    default: m_load++;
                endcase
            end
            if (push && (mcount < DEPTH || pop)) begin
                sb_q.push_back(mkrec(pc));
                mcount++;
            end else if (push) begin
                m_ovf = 1; m_drop++;
            end
            if (pop) mcount--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [15:0] p, input logic [1:0] s);
        drive(p, s, 1'b1, 1'b1);
        tick();
    endtask

    task automatic idle(input int n);
        drive(16'h0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_cycles"}, 256'(cyc),      STATS ? 256'(m_cyc)    : 256'(0));
        check({tag, "_exec"},   256'(c_exec),   STATS ? 256'(m_exec)   : 256'(0));
        check({tag, "_cache"},  256'(c_cache),  STATS ? 256'(m_cache)  : 256'(0));
        check({tag, "_branch"}, 256'(c_branch), STATS ? 256'(m_branch) : 256'(0));
        check({tag, "_load"},   256'(c_load),   STATS ? 256'(m_load)   : 256'(0));
    endtask

    initial begin
        rst = 1'b1; rst_s = 1'b1; ready = 1'b0; ready_s = 1'b0;
        drive(16'h0, 2'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        idle(2);
        check("rst_rec", 256'(rec), 256'(0));
        check("rst_ovf", 256'(ovf), 256'(0));
        check("rst_drop", 256'(drop), 256'(0));
        check_counters("rst");
        rst = 1'b0;

        // three in-order commits, consumer always ready
        ready = 1'b1;
        commit(16'h8200, 2'd0);
        commit(16'h8201, 2'd0);
        commit(16'h8202, 2'd0);
        idle(3);
        check("drain3_sb", 256'(sb_q.size()), 256'(0));

        // fill with consumer stalled, then overflow by one
        ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) commit(16'h8300 + 16'(i), 2'd0);
        commit(16'h8310, 2'd0);
        idle(1);
        check("ovf_flag", 256'(ovf), 256'(m_ovf));
        check("ovf_drop", 256'(drop), 256'(1));
        check("ovf_head_pc", 256'(rec[REC_W-1 -: 16]), 256'(16'h8300));

        // full FIFO with simultaneous pop: push accepted
        ready = 1'b1;
        commit(16'h8311, 2'd0);
        check("full_pop_drop", 256'(drop), 256'(1));
        idle(DEPTH + 2);
        check("full_pop_sb", 256'(sb_q.size()), 256'(0));

        // stall-code statistics
        rst = 1'b1; idle(1); rst = 1'b0;
        commit(16'h8400, 2'd0);
        commit(16'h8401, 2'd1);
        commit(16'h8402, 2'd1);
        commit(16'h8403, 2'd2);
        commit(16'h8404, 2'd3);
        commit(16'h8405, 2'd0);
        idle(2);
        check("stats_cycles_abs", 256'(cyc), STATS ? 256'(6) : 256'(0));
        check_counters("stats");

        // gwe=0 and i_enable=0 ignore the commit stream
        drive(16'h8500, 2'd0, 1'b0, 1'b1); tick();
        drive(16'h8501, 2'd0, 1'b1, 1'b0); tick();
        idle(2);
        check_counters("gated");

        // reset mid-drain
        ready = 1'b0;
        commit(16'h8600, 2'd0);
        commit(16'h8601, 2'd0);
        commit(16'h8602, 2'd0);
        rst = 1'b1; idle(1); rst = 1'b0;
        ready = 1'b1;
        idle(2);
        check("rstmid_ovf", 256'(ovf), 256'(0));
        check_counters("rstmid");

        // saturation on the narrow instance
        rst_s = 1'b0;
        for (int i = 0; i < 17; i++) commit(16'h8700 + 16'(i), 2'd0);
        check("sat_drop15", 256'(drop_s), 256'(4'hF));
        for (int i = 0; i < 3; i++) commit(16'h8780 + 16'(i), 2'd0);
        idle(1);
        check("sat_drop_hold", 256'(drop_s), 256'(4'hF));
        check("sat_ovf", 256'(ovf_s), 256'(1));
        check("sat_cycles", 256'(cyc_s), STATS ? 256'(4'hF) : 256'(0));
        check("sat_exec", 256'(exec_s), STATS ? 256'(4'hF) : 256'(0));
        check("sat_head_pc", 256'(rec_s[REC_W-1 -: 16]), 256'(16'h8700));
        idle(2);
        check("end_sb", 256'(sb_q.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
